// File: rtl/golay24_dec_chase_sched.sv
// Frame scheduler for the Golay(24,12) Chase candidate generator.
// Buffers {hard decision, least-reliable indexes} frames in a 2-entry FIFO
// and issues one frame at a time when the decision unit is ready, tagging it.
// Optional build macro: GOLAY24_DEC_SCHED_WATCHDOG_EN (RUN-state watchdog, drives oerr).
module golay24_dec_chase_sched #(
    parameter int unsigned pIDX_NUM = 1,
    parameter int unsigned pTAG_W   = 4
) (
    input  logic                           iclk,
    input  logic                           ireset,
    input  logic                           iclkena,
    input  logic                           ival,
    input  logic [23:0]                    ich_hd,
    input  logic [pIDX_NUM-1:0][4:0]       iidx,
    output logic                           ordy,
    output logic                           ooverflow,
    input  logic                           idec_rdy,
    output logic                           ogen_val,
    output logic [23:0]                    ogen_hd,
    output logic [pIDX_NUM-1:0][4:0]       ogen_idx,
    input  logic                           igen_eop,
    input  logic                           igen_val,
    output logic [pTAG_W-1:0]              otag,
    output logic                           obusy,
    output logic                           oerr
);

    localparam int unsigned DAT_W   = 24;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned IDX_TOT = pIDX_NUM * IDX_W;
    localparam int unsigned ENTRY_W = DAT_W + IDX_TOT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                          state_q, state_d;

    logic [ENTRY_W-1:0]              mem_q [2];
    logic                            wr_ptr_q, rd_ptr_q;
    logic [1:0]                      cnt_q, cnt_d;

    logic [DAT_W-1:0]                gen_hd_q;
    logic [pIDX_NUM-1:0][IDX_W-1:0]  gen_idx_q;
    logic [pTAG_W-1:0]               tag_q;
    logic                            ovf_q;

    logic                            push_c, pop_c, load_c, issue_c;
    logic                            fifo_ne_c, eop_c;
    logic [ENTRY_W-1:0]              head_c;

    assign ordy      = (cnt_q < 2'd2);
    assign fifo_ne_c = (cnt_q != 2'd0);
    assign eop_c     = igen_val & igen_eop;
    assign push_c    = iclkena & ival & ordy;
    assign pop_c     = iclkena & issue_c;
    assign head_c    = mem_q[rd_ptr_q];

`ifdef GOLAY24_DEC_SCHED_WATCHDOG_EN
    localparam int unsigned WD_INIT = (1 << pIDX_NUM) + 4;
    localparam int unsigned WD_W    = $clog2(WD_INIT + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_expire_c;
    logic            err_q;

    assign wd_expire_c = (state_q == ST_RUN) && !eop_c && (wd_cnt_q == WD_W'(1));

    // Watchdog: armed on issue, counts down while the generator is running
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else if (iclkena) begin
            err_q <= wd_expire_c;
            if (state_q == ST_ISSUE) begin
                wd_cnt_q <= WD_W'(WD_INIT);
            end else if (state_q == ST_RUN && wd_cnt_q != '0) begin
                wd_cnt_q <= wd_cnt_q - WD_W'(1);
            end
        end
    end

    assign oerr = err_q;
`else
    assign oerr = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q <= ST_IDLE;
        end else if (iclkena) begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_ne_c && idec_rdy) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (eop_c) begin
                    state_d = ST_IDLE;
                end
`ifdef GOLAY24_DEC_SCHED_WATCHDOG_EN
                else if (wd_expire_c) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: issue strobe and head capture on the way into ISSUE
    always_comb begin
        issue_c = 1'b0;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE:  load_c  = fifo_ne_c & idec_rdy;
            ST_ISSUE: issue_c = 1'b1;
            default: begin
                issue_c = 1'b0;
                load_c  = 1'b0;
            end
        endcase
    end

    // FIFO occupancy: push and pop in the same cycle leave it unchanged
    always_comb begin
        cnt_d = cnt_q;
        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointers and count
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (push_c) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // FIFO storage; contents are only meaningful under the count
    always_ff @(posedge iclk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {ich_hd, iidx};
        end
    end

    // Generator-facing payload and tag, held from one issue to the next
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            gen_hd_q  <= '0;
            gen_idx_q <= '0;
            tag_q     <= '1;
            ovf_q     <= 1'b0;
        end else if (iclkena) begin
            ovf_q <= ival & ~ordy;
            if (load_c) begin
                gen_hd_q  <= head_c[ENTRY_W-1 -: DAT_W];
                gen_idx_q <= head_c[IDX_TOT-1:0];
                tag_q     <= tag_q + pTAG_W'(1);
            end
        end
    end

    assign ogen_val  = (state_q == ST_ISSUE);
    assign ogen_hd   = gen_hd_q;
    assign ogen_idx  = gen_idx_q;
    assign otag      = tag_q;
    assign ooverflow = ovf_q;
    assign obusy     = (state_q != ST_IDLE) | fifo_ne_c;

endmodule
